alu_bus_master: RTL and testbench
=================================

# alu_bus_master

Bus initiator for the ALU register-mapped slave port. It accepts queued host commands (register write, register read, wait-for-interrupt), replays them as single-cycle `m_sel` transactions on the ALU slave bus, and returns read data and interrupt/timeout completions on a response port. It sits between the host/testbench sequencer and the ALU top, driving the same signal set the slave consumes.

## Interface
- `DEPTH`, 8: command FIFO entries (power of two, ≥2).
- `TIMEOUT_CYC`, 1024: maximum cycles spent in WAIT before a timeout response (only with timeout enabled).
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 2: 2'b00 WRITE, 2'b01 READ, 2'b10 WAIT_IRQ, 2'b11 reserved (treated as WAIT_IRQ).
- `cmd_addr` in 16: slave register address.
- `cmd_wdata` in 32: write data (ignored for READ/WAIT_IRQ).
- `rsp_valid` out 1: one-cycle completion pulse for READ/WAIT_IRQ.
- `rsp_data` out 32: read data; 0 for WAIT_IRQ completions.
- `rsp_err` out 1: qualified by `rsp_valid`; 1 = WAIT_IRQ timed out.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `m_sel`, `m_wr` out 1: bus select / write strobe to slave.
- `m_addr` out 16, `m_dout` out 32: to slave address / write data.
- `m_din` in 32: slave read data.
- `m_interrupt` in 1: slave interrupt, level.

## Operation
- Push on `cmd_valid && cmd_ready`; `{op,addr,wdata}` stored. `cmd_ready = !full`. Push and pop in the same cycle are allowed; count unchanged.
- FSM states: IDLE, BUS, CAPTURE, WAIT.
- IDLE: if FIFO non-empty, pop head into command register → BUS (WRITE/READ) or WAIT (WAIT_IRQ). Otherwise stay.
- BUS: `m_sel=1`, `m_wr=(op==WRITE)`, `m_addr`/`m_dout` from command register, for exactly one cycle. WRITE → IDLE; READ → CAPTURE.
- CAPTURE: `m_din` sampled at end of this cycle; next cycle `rsp_valid=1`, `rsp_data=m_din`, `rsp_err=0`; FSM → IDLE.
- WAIT: no bus activity. `m_interrupt==1` sampled → response (`rsp_data=0`, `rsp_err=0`) next cycle, → IDLE. Interrupt already high on WAIT entry completes in one cycle.
- The master never clears the interrupt; host queues the clearing WRITE explicitly.
- Reserved op behaves exactly as WAIT_IRQ.

## Timing
- Reset values: `m_sel=0`, `m_wr=0`, `m_addr=0`, `m_dout=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`, FSM IDLE, FIFO empty, `cmd_ready=1` after release.
- All outputs registered except `cmd_ready` (from registered count) and `busy`.
- Command accepted at edge N into empty idle block: popped edge N+1, `m_sel` high cycle N+2.
- WRITE occupies 2 cycles (IDLE+BUS); READ 3 cycles plus response; back-to-back commands have `m_sel` low for ≥1 cycle between transactions.
- Slave read latency fixed at one cycle after the `m_sel` cycle.
- `rsp_valid` is a pulse, no backpressure; host must sample every cycle.
- Reset mid-operation: bus strobes drop immediately, FIFO flushed, in-flight command discarded, no response issued.
- FIFO full: `cmd_ready=0`; offered command held by host, not lost.

## Configuration
- `ALU_BUS_MASTER_TIMEOUT_EN` defined: a cycle counter clears on WAIT entry; if `m_interrupt` is still low after `TIMEOUT_CYC` cycles in WAIT, issue response with `rsp_err=1`, `rsp_data=0`, → IDLE. Interrupt and timeout in the same cycle: interrupt wins (`rsp_err=0`).
- Not defined: no counter; WAIT persists until interrupt or reset; `rsp_err` tied 0; `TIMEOUT_CYC` unused.

## Structure
- Shared package `alu_bus_pkg`: op encoding typedef (WRITE/READ/WAIT_IRQ), FSM state enum, address/data width constants (16/32), command struct `{op,addr,wdata}`.
- One sub-module: `alu_cmd_fifo` (synchronous FIFO, `DEPTH` entries of the command struct, full/empty, simultaneous push/pop).

## Test plan
- WRITE addr 16'h0004 data 32'hA5A5_0001 → one-cycle `m_sel=1,m_wr=1`, `m_addr=16'h0004`, `m_dout=32'hA5A5_0001`, no `rsp_valid`.
- READ addr 16'h0010, slave model returns 32'hDEAD_BEEF → `m_sel=1,m_wr=0`, then `rsp_valid=1`, `rsp_data=32'hDEAD_BEEF`, `rsp_err=0`.
- Push 9 commands with `DEPTH=8` and FSM stalled in WAIT → `cmd_ready=0` after 8th accept; raise `m_interrupt` → WAIT response, ninth accepted, all executed in order.
- WAIT_IRQ, `m_interrupt` raised 37 cycles later → single `rsp_valid`, `rsp_err=0`, `rsp_data=0`.
- With `ALU_BUS_MASTER_TIMEOUT_EN`, `TIMEOUT_CYC=16`, no interrupt → `rsp_valid` with `rsp_err=1` after 16 WAIT cycles; next queued WRITE then issues.
- `reset` asserted during BUS cycle of a READ with 3 queued commands → `m_sel` low immediately, `busy=0`, no `rsp_valid`, nothing issued after release.

Source files
------------

// File: rtl/alu_bus_pkg.sv
// Shared types for the ALU bus master: op encoding, FSM states and the queued command word.
package alu_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_WAIT_IRQ = 2'b10,
        OP_RSVD     = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_CAPTURE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // The reserved encoding is executed exactly like WAIT_IRQ.
    function automatic op_e norm_op(input op_e op);
        return (op == OP_RSVD) ? OP_WAIT_IRQ : op;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries (power of two), simultaneous push and pop allowed.
module alu_cmd_fifo
    import alu_bus_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    // Head is visible combinationally so the controller can pop and act in one edge.
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_bus_master.sv
// Replays queued host commands as single-cycle m_sel transactions on the ALU slave bus.
// Optional WAIT timeout is compiled in with `define ALU_BUS_MASTER_TIMEOUT_EN.
module alu_bus_master
    import alu_bus_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_sel,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    input  logic              m_interrupt
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              sel_q, sel_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    cmd_t fifo_in;
    cmd_t fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign fifo_in = {op_e'(cmd_op), cmd_addr, cmd_wdata};

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (cmd_valid && !fifo_full),
        .wr_data(fifo_in),
        .pop    (fifo_pop),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef ALU_BUS_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        sel_d       = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        fifo_pop    = 1'b0;
`ifdef ALU_BUS_MASTER_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (norm_op(fifo_head.op) == OP_WAIT_IRQ) begin
                        // Keep the last bus address/data on the pins; only the op changes.
                        cmd_d.op = OP_WAIT_IRQ;
                        state_d  = ST_WAIT;
`ifdef ALU_BUS_MASTER_TIMEOUT_EN
                        tmr_d    = '0;
`endif
                    end else begin
                        cmd_d   = fifo_head;
                        state_d = ST_BUS;
                        sel_d   = 1'b1;
                        wr_d    = (fifo_head.op == OP_WRITE);
                    end
                end
            end
            ST_BUS: begin
                state_d = (cmd_q.op == OP_READ) ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = m_din;
                state_d     = ST_IDLE;
            end
            ST_WAIT: begin
                if (m_interrupt) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef ALU_BUS_MASTER_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign m_sel     = sel_q;
    assign m_wr      = wr_q;
    assign m_addr    = cmd_q.addr;
    assign m_dout    = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_bus_master.sv
// Scoreboard bench for alu_bus_master: directed timing cases plus randomized command streams.
module tb_alu_bus_master;
    import alu_bus_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        m_sel;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic [31:0] m_din;
    logic        m_interrupt;

    always #5 clk = ~clk;

    alu_bus_master #(
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .m_sel      (m_sel),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_dout     (m_dout),
        .m_din      (m_din),
        .m_interrupt(m_interrupt)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    bus_t        bus_exp[$];
    rsp_t        rsp_exp[$];
    logic [31:0] ref_mem   [256];
    logic [31:0] slave_mem [256];

    int tests = 0;
    int fails = 0;
    int rsp_count = 0;
    int last_rsp_cyc = 0;
    int cyc = 0;
    bit irq_auto = 1'b0;
    bit wait_err_exp = 1'b0;
    bit prev_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: bus transactions and responses in command order; reads see all earlier writes.
    task automatic model_push(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
        bus_t b;
        rsp_t r;
        case (op)
            2'b00: begin
                b.wr = 1'b1; b.addr = a; b.data = d;
                bus_exp.push_back(b);
                ref_mem[a[7:0]] = d;
            end
            2'b01: begin
                b.wr = 1'b0; b.addr = a; b.data = '0;
                bus_exp.push_back(b);
                r.data = ref_mem[a[7:0]]; r.err = 1'b0;
                rsp_exp.push_back(r);
            end
            default: begin
                r.data = '0; r.err = wait_err_exp;
                rsp_exp.push_back(r);
            end
        endcase
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL push_timeout: cmd_ready stuck 0 for op %0d addr %h", op, a);
            cmd_valid = 1'b0;
            return;
        end
        model_push(op, a, d);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic monitor_loop();
        bus_t b;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (m_sel) begin
                check("bus_gap_prev_sel", {31'b0, prev_sel}, 32'd0);
                if (bus_exp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_unexpected: m_sel addr %h wr %b, expected no transaction", m_addr, m_wr);
                end else begin
                    b = bus_exp.pop_front();
                    check("bus_wr", {31'b0, m_wr}, {31'b0, b.wr});
                    check("bus_addr", {16'b0, m_addr}, {16'b0, b.addr});
                    if (b.wr) check("bus_dout", m_dout, b.data);
                end
            end
            prev_sel = m_sel;
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
                if (rsp_exp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: data %h err %b, expected no response", rsp_data, rsp_err);
                end else begin
                    r = rsp_exp.pop_front();
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                end
            end
        end
    endtask

    // Slave: one-cycle read latency, garbage on m_din when not answering a read.
    task automatic slave_loop();
        forever begin
            @(posedge clk);
            if (m_sel && m_wr) slave_mem[m_addr[7:0]] = m_dout;
            if (m_sel && !m_wr) m_din <= slave_mem[m_addr[7:0]];
            else m_din <= $urandom;
        end
    endtask

    // Random interrupt pulses, never more than 9 low cycles in a row.
    task automatic irq_loop();
        int low_cnt;
        int target;
        low_cnt = 0;
        target = 3;
        forever begin
            @(negedge clk);
            if (irq_auto) begin
                if (low_cnt >= target) begin
                    m_interrupt = 1'b1;
                    low_cnt = 0;
                    target = $urandom_range(0, 8);
                end else begin
                    m_interrupt = 1'b0;
                    low_cnt++;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((busy || bus_exp.size() != 0 || rsp_exp.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check({name, "_bus_left"}, 32'(bus_exp.size()), 32'd0);
        check({name, "_rsp_left"}, 32'(rsp_exp.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  op;
        int          rc;
        int          t0;
        int          g;
        int          irq_delay;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        m_interrupt = 1'b0; m_din = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
            slave_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
        end
        ref_mem[8'h10]   = 32'hDEAD_BEEF;
        slave_mem[8'h10] = 32'hDEAD_BEEF;
        fork
            monitor_loop();
            slave_loop();
            irq_loop();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_m_sel", {31'b0, m_sel}, 32'd0);
        check("rst_m_wr", {31'b0, m_wr}, 32'd0);
        check("rst_m_addr", {16'b0, m_addr}, 32'd0);
        check("rst_m_dout", m_dout, 32'd0);
        check("rst_rsp", {rsp_valid, rsp_err, 30'b0} | rsp_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Directed WRITE with latency check
        push_cmd(2'b00, 16'h0004, 32'hA5A5_0001);
        @(negedge clk);
        check("wr_lat_idle", {31'b0, m_sel}, 32'd0);
        @(negedge clk);
        check("wr_sel", {30'b0, m_sel, m_wr}, 32'd3);
        check("wr_addr", {16'b0, m_addr}, 32'h0004);
        check("wr_dout", m_dout, 32'hA5A5_0001);
        @(negedge clk);
        check("wr_sel_drop", {31'b0, m_sel}, 32'd0);

        // Directed READ
        push_cmd(2'b01, 16'h0010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rd_sel", {30'b0, m_sel, m_wr}, 32'd2);
        @(negedge clk);
        check("rd_capture_no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
        drain("directed");

        // FIFO full while stalled in WAIT
        push_cmd(2'b10, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            push_cmd((i % 2 == 0) ? 2'b00 : 2'b01, {8'h00, r[7:0]}, $urandom);
        end
        @(negedge clk);
        check("full_ready_low", {31'b0, cmd_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd1);
        rc = rsp_count;
        fork
            push_cmd(2'b00, 16'h00AB, 32'h9999_0009);
            begin
                repeat (6) @(negedge clk);
                check("full_hold_ready", {31'b0, cmd_ready}, 32'd0);
                check("full_no_rsp", 32'(rsp_count - rc), 32'd0);
                m_interrupt = 1'b1;
                @(negedge clk);
                m_interrupt = 1'b0;
            end
        join
        drain("full");

        // WAIT_IRQ released by a late interrupt
`ifdef ALU_BUS_MASTER_TIMEOUT_EN
        irq_delay = 10;
`else
        irq_delay = 37;
`endif
        rc = rsp_count;
        push_cmd(2'b11, 16'h0, 32'h0);
        repeat (irq_delay) @(negedge clk);
        check("irq_no_early", 32'(rsp_count - rc), 32'd0);
        m_interrupt = 1'b1;
        @(negedge clk);
        m_interrupt = 1'b0;
        repeat (4) @(negedge clk);
        check("irq_single_rsp", 32'(rsp_count - rc), 32'd1);
        drain("irq");

`ifdef ALU_BUS_MASTER_TIMEOUT_EN
        wait_err_exp = 1'b1;
        push_cmd(2'b10, 16'h0, 32'h0);
        t0 = cyc;
        wait_err_exp = 1'b0;
        push_cmd(2'b00, 16'h0040, 32'h1234_5678);
        g = 0;
        while (rsp_exp.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("tmo_latency", 32'(last_rsp_cyc - t0), 32'd17);
        drain("timeout");
`endif

        // Randomized mix with automatic interrupts
        irq_auto = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = $urandom;
            op = r[17:16];
            push_cmd(op, r[15:0], $urandom);
        end
        drain("random");
        irq_auto = 1'b0;
        @(negedge clk);
        m_interrupt = 1'b0;

        // Reset during the BUS cycle of a READ with three commands queued behind it
        push_cmd(2'b10, 16'h0, 32'h0);
        push_cmd(2'b01, 16'h0020, 32'h0);
        push_cmd(2'b01, 16'h0021, 32'h0);
        push_cmd(2'b10, 16'h0, 32'h0);
        push_cmd(2'b01, 16'h0022, 32'h0);
        @(negedge clk);
        m_interrupt = 1'b1;
        @(negedge clk);
        m_interrupt = 1'b0;
        g = 0;
        while (!m_sel && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_saw_bus", {31'b0, m_sel}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_sel_drop", {31'b0, m_sel}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
        bus_exp.delete();
        rsp_exp.delete();
        rc = rsp_count;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_after_no_rsp", 32'(rsp_count - rc), 32'd0);
        check("rst_after_busy", {31'b0, busy}, 32'd0);
        check("rst_after_ready", {31'b0, cmd_ready}, 32'd1);
        push_cmd(2'b00, 16'h0030, 32'hC0DE_0030);
        push_cmd(2'b01, 16'h0030, 32'h0);
        drain("resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
